// File: rtl/dcache_port_arbiter.sv
// Shares the single dcache request port between NUM_REQ issue lanes, round-robin, one access in flight.
// Latency: dc_valid combinational from the selected lane in IDLE; response routed back with zero added latency.
// Backpressure: pause_mem holds the pipeline until every valid lane in the current group has completed.
module dcache_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                resp_valid,
  output logic [DATA_WIDTH-1:0]             resp_rdata,
  output logic                              dc_valid,
  output logic                              dc_we,
  output logic [ADDR_WIDTH-1:0]             dc_addr,
  output logic [DATA_WIDTH-1:0]             dc_wdata,
  output logic [DATA_WIDTH/8-1:0]           dc_wstrb,
  input  logic                              dc_addr_ok,
  input  logic                              dc_data_ok,
  input  logic [DATA_WIDTH-1:0]             dc_rdata,
  output logic                              pause_mem
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic                hold_we_q, hold_we_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
  logic [STRB_W-1:0]   hold_wstrb_q, hold_wstrb_d;
  // Lanes already completed while the pipeline is still paused; they stay
  // valid until pause_mem drops, so they must not be served twice.
  logic [NUM_REQ-1:0]  done_q, done_d;

  logic [NUM_REQ-1:0]  pending;
  logic                sel_found;
  int                  sel_i;
  int                  idx;
  logic [IDW-1:0]      sel_id;
  logic                sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_W-1:0]   sel_wstrb;

  // Round-robin pick: first pending lane at or after rr_ptr, wrapping.
  always_comb begin
    pending   = req_valid & ~done_q;
    sel_found = 1'b0;
    sel_i     = 0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!sel_found && pending[idx]) begin
        sel_found = 1'b1;
        sel_i     = idx;
      end
    end
    sel_id    = IDW'(sel_i);
    sel_we    = req_we[sel_i];
    sel_addr  = req_addr[sel_i*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = req_wdata[sel_i*DATA_WIDTH +: DATA_WIDTH];
    sel_wstrb = req_wstrb[sel_i*STRB_W +: STRB_W];
  end

  // Transaction FSM: next state, holding registers and port outputs.
  // Everything is forced idle while rst is high so outputs read 0 in reset.
  // The handshake with dcache is only honoured from REQ; the IDLE-cycle
  // dc_valid is an early presentation of the same request.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_wstrb_d = hold_wstrb_q;
    req_ready    = '0;
    resp_valid   = '0;
    resp_rdata   = '0;
    dc_valid     = 1'b0;
    dc_we        = 1'b0;
    dc_addr      = '0;
    dc_wdata     = '0;
    dc_wstrb     = '0;

    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (sel_found && !flush) begin
            dc_valid     = 1'b1;
            dc_we        = sel_we;
            dc_addr      = sel_addr;
            dc_wdata     = sel_wdata;
            dc_wstrb     = sel_wstrb;
            grant_id_d   = sel_id;
            hold_we_d    = sel_we;
            hold_addr_d  = sel_addr;
            hold_wdata_d = sel_wdata;
            hold_wstrb_d = sel_wstrb;
            state_d      = S_REQ;
          end
        end
        S_REQ: begin
          dc_valid = 1'b1;
          dc_we    = hold_we_q;
          dc_addr  = hold_addr_q;
          dc_wdata = hold_wdata_q;
          dc_wstrb = hold_wstrb_q;
          if (dc_addr_ok) begin
            // Once accepted the access is committed; a concurrent flush
            // only means its response gets thrown away.
            rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
            if (flush) begin
              state_d = S_DRAIN;
            end else begin
              req_ready[grant_id_q] = 1'b1;
              state_d               = S_WAIT;
            end
          end else if (flush) begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (dc_data_ok) begin
            if (!flush) begin
              resp_valid[grant_id_q] = 1'b1;
              resp_rdata             = dc_rdata;
            end
            state_d = S_IDLE;
          end else if (flush) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (dc_data_ok) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pause while any valid lane is neither done nor completing this cycle;
  // the done mask clears whenever the pipeline is allowed to advance.
  always_comb begin
    pause_mem = !rst && !flush && (|(req_valid & ~done_q & ~resp_valid));
    if (flush || !pause_mem) done_d = '0;
    else                     done_d = done_q | resp_valid;
  end

  // State and holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_wstrb_q <= '0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_wstrb_q <= hold_wstrb_d;
      done_q       <= done_d;
    end
  end

endmodule
